// File: rtl/button_event_decoder_pkg.sv
// -----------------------------------------------------------------------------
// btn_event_pkg
// Shared definitions for the button event decoder:
//   - btn_state_e : FSM state encoding (IDLE=0, PRESS=1, GAP=2, HELD=3)
//   - DEF_*       : default hold / gap durations and counter width
//                   (5 s long press and 300 ms gap window at 50 MHz)
//   - SIM_*       : short durations used for simulation
//   - is_holding  : true for the states in which the button counts as held
// The double-press feature is selected by the BTN_DOUBLE_EN macro in
// button_event_decoder.sv; the encoding here does not depend on it.
// -----------------------------------------------------------------------------
package btn_event_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_GAP   = 2'd2,
      ST_HELD  = 2'd3
   } btn_state_e;

   localparam int unsigned DEF_LONG_CYCLES = 250000000;
   localparam int unsigned DEF_GAP_CYCLES  = 15000000;
   localparam int unsigned DEF_CNT_W       = 28;

   localparam int unsigned SIM_LONG_CYCLES = 20;
   localparam int unsigned SIM_GAP_CYCLES  = 8;

   function automatic logic is_holding(input btn_state_e st);
      return (st == ST_PRESS) || (st == ST_HELD);
   endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// -----------------------------------------------------------------------------
// button_event_decoder_if
// Signal bundle between a button decoder and its surroundings.
//   en, db_level                       : driven by the master (control side)
//   press_short/press_long/press_double: single-cycle event pulses
//   holding                            : level, button considered held
//   state_dbg                          : current FSM state encoding
// Valid/ready note: there is no backpressure; each event pulse is valid for
// exactly one cycle and the consumer must accept it in that cycle.
// Modports: master (control FSM / testbench), slave (decoder).
// -----------------------------------------------------------------------------
interface button_event_decoder_if;

   logic       en;
   logic       db_level;
   logic       press_short;
   logic       press_long;
   logic       press_double;
   logic       holding;
   logic [1:0] state_dbg;

   modport master (
      output en,
      output db_level,
      input  press_short,
      input  press_long,
      input  press_double,
      input  holding,
      input  state_dbg
   );

   modport slave (
      input  en,
      input  db_level,
      output press_short,
      output press_long,
      output press_double,
      output holding,
      output state_dbg
   );

endinterface

// File: rtl/button_event_decoder_hold_timer.sv
// -----------------------------------------------------------------------------
// hold_timer
// CNT_W-bit up counter with synchronous clear and count enable, plus a
// terminal compare against one of two limits.
//   clk, reset : clock, asynchronous active-high reset
//   clear_i    : force counter to 0 (has priority over en_i)
//   en_i       : increment by 1
//   sel_i      : 0 -> compare against LIMIT_A, 1 -> compare against LIMIT_B
//   term_o     : high while count == selected limit - 1
// -----------------------------------------------------------------------------
module hold_timer #(
   parameter int unsigned CNT_W   = 28,
   parameter int unsigned LIMIT_A = 2,
   parameter int unsigned LIMIT_B = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic en_i,
   input  logic sel_i,
   output logic term_o
);

   localparam logic [CNT_W-1:0] LIM_A_M1 = CNT_W'(LIMIT_A - 1);
   localparam logic [CNT_W-1:0] LIM_B_M1 = CNT_W'(LIMIT_B - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign term_o = (cnt_q == (sel_i ? LIM_B_M1 : LIM_A_M1));

endmodule

// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
// Turns a debounced button level into single-cycle user events: short press,
// long press (hold for LONG_CYCLES) and, when BTN_DOUBLE_EN is defined, double
// press (re-press within GAP_CYCLES of a release). Without BTN_DOUBLE_EN the
// GAP state is unreachable, press_double is 0 and a short press is reported
// right after the release.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : button_event_decoder_if.slave (en, db_level in; events,
//                holding, state_dbg out). All outputs are registered.
// -----------------------------------------------------------------------------
module button_event_decoder
   import btn_event_pkg::*;
#(
   parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES,
   parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic                         clk,
   input  logic                         reset,
   button_event_decoder_if.slave        bus
);

   btn_state_e state_q, state_d;
   logic       db_prev_q;
   logic       rise, fall;
   logic       term;
   logic       short_q, short_d;
   logic       long_q, long_d;
   logic       double_q, double_d;
   logic       holding_q, holding_d;

   assign rise = bus.db_level & ~db_prev_q;
   assign fall = ~bus.db_level & db_prev_q;

   // Counter restarts on every state change; it only needs to run in the
   // states that have a time limit.
   hold_timer #(
      .CNT_W   (CNT_W),
      .LIMIT_A (LONG_CYCLES),
      .LIMIT_B (GAP_CYCLES)
   ) u_hold_timer (
      .clk     (clk),
      .reset   (reset),
      .clear_i ((state_d != state_q) || !bus.en),
      .en_i    ((state_q == ST_PRESS) || (state_q == ST_GAP)),
      .sel_i   (state_q == ST_GAP),
      .term_o  (term)
   );

   // State / output register. db_prev resets to 1 so a button held through
   // reset must be released and pressed again before anything happens.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         db_prev_q <= 1'b1;
         short_q   <= 1'b0;
         long_q    <= 1'b0;
         double_q  <= 1'b0;
         holding_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         db_prev_q <= bus.db_level;
         short_q   <= short_d;
         long_q    <= long_d;
         double_q  <= double_d;
         holding_q <= holding_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (!bus.en) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE:  if (rise) state_d = ST_PRESS;
            ST_PRESS: begin
               if (bus.db_level && term) begin
                  state_d = ST_HELD;
               end else if (fall) begin
`ifdef BTN_DOUBLE_EN
                  state_d = ST_GAP;
`else
                  state_d = ST_IDLE;
`endif
               end
            end
            ST_GAP: begin
`ifdef BTN_DOUBLE_EN
               // A re-press takes priority over window expiry.
               if (rise)      state_d = ST_HELD;
               else if (term) state_d = ST_IDLE;
`else
               state_d = ST_IDLE;
`endif
            end
            ST_HELD:  if (fall) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Output logic: event pulses accompany the transitions above.
   always_comb begin
      short_d   = 1'b0;
      long_d    = 1'b0;
      double_d  = 1'b0;
      holding_d = is_holding(state_d);
      if (bus.en) begin
         unique case (state_q)
            ST_PRESS: begin
               if (bus.db_level && term) begin
                  long_d = 1'b1;
               end else if (fall) begin
`ifndef BTN_DOUBLE_EN
                  short_d = 1'b1;
`endif
               end
            end
            ST_GAP: begin
`ifdef BTN_DOUBLE_EN
               if (rise)      double_d = 1'b1;
               else if (term) short_d  = 1'b1;
`endif
            end
            default: ;
         endcase
      end
   end

   assign bus.press_short  = short_q;
   assign bus.press_long   = long_q;
   assign bus.press_double = double_q;
   assign bus.holding      = holding_q;
   assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_button_event_decoder
// Directed scenarios plus randomized level/enable runs, compared every cycle
// against a reference model that tracks press and release times.
// Works with and without BTN_DOUBLE_EN.
// -----------------------------------------------------------------------------
module tb_button_event_decoder;
  import btn_event_pkg::*;

  localparam int LONG = SIM_LONG_CYCLES;
  localparam int GAP  = SIM_GAP_CYCLES;
  localparam int W    = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  button_event_decoder_if bus_if ();

  button_event_decoder #(
    .LONG_CYCLES (LONG),
    .GAP_CYCLES  (GAP),
    .CNT_W       (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check_vec(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {hold,st,s,l,d}=%b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] observed();
    return {bus_if.holding, bus_if.state_dbg, bus_if.press_short,
            bus_if.press_long, bus_if.press_double};
  endfunction

  // ---------------- reference model ----------------
  // Tracks when the current press began (m_press_t), when the pending short
  // release happened (m_rel_t) and whether the press is already consumed by
  // a long/double event (m_latched). Times are clock-edge indices.
  bit m_prev;
  int m_t;
  int m_press_t;
  int m_rel_t;
  bit m_latched;

  task automatic model_reset();
    m_prev = 1'b1; m_t = 0; m_press_t = -1; m_rel_t = -1; m_latched = 1'b0;
  endtask

  task automatic model_step(input bit lvl, input bit en_v);
    bit rise, fall, ev_s, ev_l, ev_d;
    logic [1:0] st;
    rise = lvl && !m_prev;
    fall = !lvl && m_prev;
    ev_s = 0; ev_l = 0; ev_d = 0;
    m_t++;
    if (!en_v) begin
      m_press_t = -1; m_rel_t = -1; m_latched = 0;
    end else if (m_latched) begin
      if (fall) m_latched = 0;
    end else if (m_press_t >= 0) begin
      if (lvl && (m_t - m_press_t == LONG)) begin
        ev_l = 1; m_latched = 1; m_press_t = -1;
      end else if (fall) begin
        m_press_t = -1;
`ifdef BTN_DOUBLE_EN
        m_rel_t = m_t;
`else
        ev_s = 1;
`endif
      end
    end else if (m_rel_t >= 0) begin
      if (rise) begin
        ev_d = 1; m_latched = 1; m_rel_t = -1;
      end else if (m_t - m_rel_t == GAP) begin
        ev_s = 1; m_rel_t = -1;
      end
    end else if (rise) begin
      m_press_t = m_t;
    end
    m_prev = lvl;
    st = m_latched ? 2'd3 : (m_press_t >= 0) ? 2'd1 : (m_rel_t >= 0) ? 2'd2 : 2'd0;
    exp_q.push_back({(m_latched || m_press_t >= 0), st, ev_s, ev_l, ev_d});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit lvl, input bit en_v, input string tag);
    bus_if.db_level = lvl;
    bus_if.en       = en_v;
    @(posedge clk);
    model_step(lvl, en_v);
    #1;
    check_vec(tag, observed(), exp_q.pop_front());
  endtask

  task automatic run(input bit lvl, input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(lvl, 1'b1, tag);
  endtask

  // Asserts reset away from the clock edge; outputs must clear immediately.
  task automatic do_reset(input bit lvl, input string tag);
    bus_if.db_level = lvl;
    reset = 1'b1;
    #1;
    check_vec({tag, "_async"}, observed(), '0);
    model_reset();
    @(posedge clk);
    #1;
    check_vec({tag, "_held"}, observed(), '0);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int left;
    bit lvl, en_v;
    reset = 1'b1;
    bus_if.en = 1'b1;
    bus_if.db_level = 1'b0;
    model_reset();
    do_reset(1'b0, "rst_init");

    run(0, 3, "idle");

    // short press
    run(1, 5, "short_press");
    run(0, GAP + 4, "short_release");

    // long hold then release
    run(1, 30, "long_hold");
    run(0, GAP + 4, "long_release");

    // press 3, release 4, press 3
    run(1, 3, "dbl_p1");
    run(0, 4, "dbl_gap");
    run(1, 3, "dbl_p2");
    run(0, GAP + 4, "dbl_release");

    // second rise exactly at gap expiry
    run(1, 3, "edge_p1");
    run(0, GAP, "edge_gap");
    run(1, 3, "edge_p2");
    run(0, GAP + 4, "edge_release");

    // button held through reset
    run(1, 2, "pre_rst_hold");
    do_reset(1'b1, "rst_held");
    run(1, 25, "held_thru_rst");
    run(0, 3, "held_release");
    run(1, 4, "fresh_press");
    run(0, GAP + 4, "fresh_release");

    // enable dropped at cycle 10 of a hold
    run(1, 10, "en_hold");
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, "en_low");
    run(1, 25, "en_back_hold");
    run(0, GAP + 4, "en_release");

    // reset while a short press is pending
    run(1, 3, "rgap_press");
    run(0, 3, "rgap_release");
    do_reset(1'b0, "rst_gap");
    run(0, GAP + 4, "rgap_after");

    // randomized runs of level and enable
    left = 0;
    lvl = 0;
    en_v = 1;
    for (int i = 0; i < 2000; i++) begin
      if (left == 0) begin
        lvl  = ~lvl;
        en_v = ($urandom_range(0, 19) != 0);
        left = (int'($urandom_range(0, 3)) == 0) ? int'($urandom_range(LONG - 2, LONG + 6))
                                                 : int'($urandom_range(1, GAP + 2));
      end
      if ($urandom_range(0, 399) == 0) do_reset(lvl, "rst_rand");
      else cycle(lvl, en_v, "random");
      left--;
    end
    run(0, LONG + GAP, "drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Classifies the debounced button level into discrete user events: short press, long press (hold), and optionally double press. Sits directly downstream of the per-button debouncer and upstream of the game/menu control FSM, which consumes only single-cycle event pulses. One instance per physical button.

## Interface

Parameters:
- LONG_CYCLES, 250000000: hold duration (clk cycles) that qualifies a long press (5 s at 50 MHz); must be ≥ 2.
- GAP_CYCLES, 15000000: maximum release-to-repress window (clk cycles) for a double press (300 ms at 50 MHz); must be ≥ 2.
- CNT_W, 28: counter width; 2^CNT_W must exceed max(LONG_CYCLES, GAP_CYCLES).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  decoder enable; low forces IDLE and suppresses all events.
- db_level  input  1  debounced button level (1 = pressed), already synchronous to clk.
- press_short  output  1  one-cycle pulse, short press recognised.
- press_long  output  1  one-cycle pulse, hold reached LONG_CYCLES.
- press_double  output  1  one-cycle pulse, second press inside the gap window.
- holding  output  1  level, high while the FSM is in PRESS or HELD.
- state_dbg  output  2  current FSM state encoding.

## Operation

- db_prev: registered copy of db_level. rise = db_level & ~db_prev; fall = ~db_level & db_prev.
- Single counter cnt (CNT_W bits), cleared to 0 on every state change, increments by 1 each cycle otherwise. It never wraps because each state exits at its limit.
- States (encoding): IDLE=0, PRESS=1, GAP=2, HELD=3.
- IDLE: rise → PRESS.
- PRESS: db_level high and cnt == LONG_CYCLES-1 → press_long, HELD. fall → GAP (with BTN_DOUBLE_EN) or press_short and IDLE (without).
- GAP: rise → press_double, HELD. cnt == GAP_CYCLES-1 with no rise → press_short, IDLE. If rise and expiry occur in the same cycle, rise wins.
- HELD: fall → IDLE, with no event. Nothing is emitted on release after a long or double press.
- en low: next state IDLE, cnt 0, all pulses 0. db_prev keeps tracking db_level.
- At most one event pulse is high in any cycle.

## Timing

- Reset values: state IDLE, cnt 0, db_prev 1, all outputs 0. db_prev resets to 1 so that a button held through reset produces no event until it is released and pressed again.
- All outputs are registered.
- Edge 0 is defined as the clock edge that samples rise.
- press_long is high in the cycle following edge LONG_CYCLES, provided db_level is high through that edge.
- Short press without BTN_DOUBLE_EN: press_short is high in the cycle after the edge that samples fall.
- Short press with BTN_DOUBLE_EN: press_short is high in the cycle after edge GAP_CYCLES, counted from the edge that sampled fall.
- press_double is high in the cycle after the edge that samples the second rise.
- holding follows state: it goes high 1 cycle after rise and low 1 cycle after fall.
- Reset asserted mid-operation: all outputs clear immediately (asynchronous), and no pending event survives.

## Configuration

- BTN_DOUBLE_EN defined: GAP state, press_double, and GAP_CYCLES are active. press_short is deferred by the gap window.
- BTN_DOUBLE_EN undefined:
  - GAP is unreachable; PRESS fall goes directly to press_short and IDLE.
  - press_double is tied to 0 and GAP_CYCLES is ignored.
  - The state encoding is unchanged.

## Structure

- Shared package btn_event_pkg holds:
  - the state encodings IDLE/PRESS/GAP/HELD;
  - default LONG_CYCLES, GAP_CYCLES and CNT_W;
  - simulation-scale constants (LONG 20, GAP 8).
- One sub-module, hold_timer: a CNT_W counter with clear, enable and a terminal-compare output against a selectable limit. The FSM stays in button_event_decoder.

## Test plan

All scenarios use LONG_CYCLES=20 and GAP_CYCLES=8.

- Press for 5 cycles, then release:
  - with BTN_DOUBLE_EN, press_short pulses once, 8 cycles after the fall edge;
  - without it, press_short pulses 1 cycle after the fall;
  - no other pulses occur.
- Hold for 30 cycles: press_long pulses once at edge 20, holding stays 1 until the release, and no press_short follows.
- Press 3, release 4, press 3 (BTN_DOUBLE_EN): press_double pulses 1 cycle after the second rise, with no press_short at any point.
- Drive the second rise in the same cycle as GAP expiry (cnt=7): press_double is emitted, not press_short.
- Reset while db_level=1, release reset, keep holding for 25 cycles: no events; a subsequent release and re-press behaves as a fresh press.
- Drop en at cycle 10 of a hold: state goes to IDLE and no press_long is emitted. Assert reset mid-GAP: outputs are 0 and the pending press_short is discarded.
